// File: rtl/cpu_to_noc_flitizer_fifo.sv
// Purpose : packs DATA_W-bit CPU beats into FLIT_W-bit flits, checks framing and the
//           bytewise-XOR checksum, and queues good flits toward the NoC inject port.
// Latency : 1 cycle from final-beat accept to pushed_flit_valid (FIFO empty case).
// Backpr. : data_in_rdy drops when the FIFO is full or ingress is halted after an error
//           (ERR_MODE=1); the NoC side pops with pushed_flit_valid & pushed_flit_ready.
// Ports   : nocclk/rst_n clock and async active-low reset; data_in/_vld/_last/_rdy CPU
//           beat channel; sys_clear error-clear pulse; pushed_flit/_valid/_ready FIFO head;
//           sys_invalid_flit sticky error flag; err_count saturating drop count;
//           fifo_level current occupancy.
module cpu_to_noc_flitizer_fifo #(
    parameter int DATA_W   = 32,
    parameter int FLIT_W   = 128,
    parameter int DEPTH    = 4,
    parameter int ERR_MODE = 0
) (
    input  logic                     nocclk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     data_in_vld,
    input  logic                     data_in_last,
    output logic                     data_in_rdy,
    input  logic                     sys_clear,
    output logic [FLIT_W-1:0]        pushed_flit,
    output logic                     pushed_flit_valid,
    input  logic                     pushed_flit_ready,
    output logic                     sys_invalid_flit,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int BEATS = FLIT_W / DATA_W;
    localparam int CW    = $clog2(BEATS);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [CW-1:0]     r_beat_cnt;
    logic [FLIT_W-1:0] r_asm;
    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              r_halt;
    logic              r_invalid;
    logic [7:0]        r_err_cnt;

    logic              w_full;
    logic              w_accept;
    logic              w_is_last;
    logic              w_frame_err;
    logic              w_complete;
    logic              w_cks_err;
    logic              w_err;
    logic              w_push;
    logic              w_pop;
    logic [FLIT_W-1:0] w_flit;
    logic [7:0]        w_cks;

    // Full when the wrap bits differ but the index bits match.
    assign w_full = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // rst_n is folded in so the CPU sees not-ready for the whole reset window.
    assign data_in_rdy = rst_n & ~r_halt & ~w_full;
    assign w_accept    = data_in_vld & data_in_rdy;
    assign w_is_last   = (r_beat_cnt == LAST_BEAT);

    // A last marker must coincide exactly with the final beat position.
    assign w_frame_err = w_accept & (data_in_last ^ w_is_last);
    assign w_complete  = w_accept & w_is_last & data_in_last;

    // The final beat is never stored: the flit is the held lower beats plus live data_in.
    always_comb begin
        w_flit = r_asm;
        w_flit[FLIT_W-1 -: DATA_W] = data_in;
    end

    always_comb begin
        w_cks = 8'h00;
        for (int i = 0; i < FLIT_W / 8; i++) begin
            w_cks = w_cks ^ w_flit[i*8 +: 8];
        end
    end

    assign w_cks_err = w_complete & (w_cks != 8'h00);
    assign w_err     = w_frame_err | w_cks_err;
    // A clear in the accept cycle discards the beat, so a good final beat is not queued;
    // errors are still recorded because an error outranks the clear.
    assign w_push    = w_complete & (w_cks == 8'h00) & ~sys_clear;
    assign w_pop     = pushed_flit_valid & pushed_flit_ready;

    // Beat counter and assembly register.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_asm      <= '0;
        end else begin
            if (sys_clear || w_frame_err || w_complete) begin
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CW'(1);
            end
            if (w_accept && !sys_clear) begin
                for (int k = 0; k < BEATS - 1; k++) begin
                    if (r_beat_cnt == CW'(k)) begin
                        r_asm[k*DATA_W +: DATA_W] <= data_in;
                    end
                end
            end
        end
    end

    // Error flag, saturating counter and halt. The error term is tested first so
    // that a coincident clear yields flag=1 and a count restarting at 1.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            r_invalid <= 1'b0;
            r_err_cnt <= 8'h00;
            r_halt    <= 1'b0;
        end else begin
            if (w_err) begin
                r_invalid <= 1'b1;
                if (sys_clear) begin
                    r_err_cnt <= 8'h01;
                end else if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (sys_clear) begin
                r_invalid <= 1'b0;
                r_err_cnt <= 8'h00;
            end
            if ((ERR_MODE != 0) && w_err) begin
                r_halt <= 1'b1;
            end else if (sys_clear) begin
                r_halt <= 1'b0;
            end
        end
    end

    // FIFO pointers; the storage array itself needs no reset.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge nocclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_flit;
        end
    end

    assign pushed_flit       = r_mem[r_rd_ptr[AW-1:0]];
    assign pushed_flit_valid = (r_wr_ptr != r_rd_ptr);
    assign fifo_level        = r_wr_ptr - r_rd_ptr;
    assign sys_invalid_flit  = r_invalid;
    assign err_count         = r_err_cnt;

endmodule
